// File: rtl/door_passage_decoder.sv
// door_passage_decoder: debounces the outer/inner doorway beams and decodes passage order into entered/exited/denied pulses.
// Optional macro BEAM_DEBOUNCE_EN enables the DEBOUNCE-edge filters; otherwise each beam is a single register.
module door_passage_decoder #(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       beam_out,
    input  logic       beam_in,
    input  logic       entry_lock,
    input  logic       exit_lock,
    output logic       entered,
    output logic       exited,
    output logic       denied,
    output logic       fault,
    output logic       busy,
    output logic [2:0] state_dbg
);
    // 4-bit state: DENY and FAULT both show 7 on state_dbg, told apart by the fault output.
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ENT1  = 4'd1,
        ENT2  = 4'd2,
        ENT3  = 4'd3,
        EXT1  = 4'd4,
        EXT2  = 4'd5,
        EXT3  = 4'd6,
        DENY  = 4'd7,
        FAULT = 4'd15
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    if (DEBOUNCE < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("DEBOUNCE and TIMEOUT must be at least 1");
    end

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    raw, filt_q, filt_d;
    logic          entered_q, entered_d, exited_q, exited_d, denied_q, denied_d;
    logic          passage;

    assign raw = {beam_out, beam_in};

`ifdef BEAM_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE + 1);
    logic [DW-1:0] cnt_q [2];
    logic [DW-1:0] cnt_d [2];

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (raw[i] != filt_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE - 1)) filt_d[i] = raw[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign filt_d = raw;
`endif

    assign passage = (state_q != IDLE) && (state_q != DENY) && (state_q != FAULT);

    always_comb begin
        state_d   = state_q;
        entered_d = 1'b0;
        exited_d  = 1'b0;
        denied_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (filt_q == 2'b10) begin
                    state_d  = entry_lock ? DENY : ENT1;
                    denied_d = entry_lock;
                end else if (filt_q == 2'b01) begin
                    state_d  = exit_lock ? DENY : EXT1;
                    denied_d = exit_lock;
                end else if (filt_q == 2'b11) begin
                    state_d = FAULT;
                end
            end
            ENT1: state_d = filt_q == 2'b11 ? ENT2 : filt_q == 2'b00 ? IDLE : filt_q == 2'b01 ? FAULT : ENT1;
            ENT2: state_d = filt_q == 2'b01 ? ENT3 : filt_q == 2'b10 ? ENT1 : filt_q == 2'b00 ? FAULT : ENT2;
            ENT3: begin
                state_d   = filt_q == 2'b00 ? IDLE : filt_q == 2'b11 ? ENT2 : filt_q == 2'b10 ? FAULT : ENT3;
                entered_d = filt_q == 2'b00;
            end
            EXT1: state_d = filt_q == 2'b11 ? EXT2 : filt_q == 2'b00 ? IDLE : filt_q == 2'b10 ? FAULT : EXT1;
            EXT2: state_d = filt_q == 2'b10 ? EXT3 : filt_q == 2'b01 ? EXT1 : filt_q == 2'b00 ? FAULT : EXT2;
            EXT3: begin
                state_d  = filt_q == 2'b00 ? IDLE : filt_q == 2'b11 ? EXT2 : filt_q == 2'b01 ? FAULT : EXT3;
                exited_d = filt_q == 2'b00;
            end
            DENY, FAULT: state_d = filt_q == 2'b00 ? IDLE : state_q;
            default: state_d = IDLE;
        endcase
        // A stalled passage faults on its TIMEOUT-th cycle in the same state, dropping any completion.
        if (passage && tmo_q == TW'(TIMEOUT - 1)) begin
            state_d   = FAULT;
            entered_d = 1'b0;
            exited_d  = 1'b0;
        end
        tmo_d = (passage && state_d == state_q) ? tmo_q + 1'b1 : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            filt_q    <= '0;
            entered_q <= 1'b0;
            exited_q  <= 1'b0;
            denied_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            filt_q    <= filt_d;
            entered_q <= entered_d;
            exited_q  <= exited_d;
            denied_q  <= denied_d;
        end
    end

    assign entered   = entered_q;
    assign exited    = exited_q;
    assign denied    = denied_q;
    assign fault     = state_q == FAULT;
    assign busy      = state_q != IDLE;
    assign state_dbg = state_q[2:0];
endmodule
